// File: rtl/pixel_write_queue.sv
// Clips incoming pixels to the screen, queues them in a FIFO and writes them
// in order through a stallable framebuffer port, flagging pixels lost to a full queue.
module pixel_write_queue #(
  parameter int DEPTH    = 16,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       draw,
  input  logic [8:0]                 x_in,
  input  logic [7:0]                 y_in,
  input  logic [COLOR_W-1:0]         color,
  input  logic                       clear_ovf,
  input  logic                       fb_ready,
  output logic                       fb_we,
  output logic [ADDR_W-1:0]          fb_addr,
  output logic [COLOR_W-1:0]         fb_data,
  output logic                       busy,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [8:0]       X_LIM = 9'(SCREEN_W);
  localparam logic [7:0]       Y_LIM = 8'(SCREEN_H);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  typedef enum logic {S_EMPTY, S_VALID} out_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  out_state_t         state, state_next;

  logic               in_range, push, drop, load, fifo_empty;
  logic [ADDR_W-1:0]  x_ext, y_ext, push_addr;

  assign in_range   = (x_in < X_LIM) && (y_in < Y_LIM);
  assign fifo_empty = (count == '0);
  // Full is judged on the pre-edge count, so a same-edge pop never rescues a draw.
  assign push       = draw && in_range && (count != FULL);
  assign drop       = draw && in_range && (count == FULL);

  // y*320 as (y<<8)+(y<<6); 17 bits holds the largest address 76799 without truncation.
  assign x_ext     = ADDR_W'(x_in);
  assign y_ext     = ADDR_W'(y_in);
  assign push_addr = (y_ext << 8) + (y_ext << 6) + x_ext;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    load       = 1'b0;
    case (state)
      S_EMPTY: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        if (fb_ready) begin
          load       = !fifo_empty;
          state_next = fifo_empty ? S_EMPTY : S_VALID;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        fb_addr <= mem[rd_ptr].addr;
        fb_data <= mem[rd_ptr].data;
      end
      count <= count + CNT_W'(push) - CNT_W'(load);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; pointers and count define validity, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: push_addr, data: color};
  end

  assign fb_we = (state == S_VALID);
  assign busy  = !fifo_empty || fb_we;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed bench for pixel_write_queue: latency, stall, overflow, clipping,
// async reset, and a scoreboarded random run with a toggling fb_ready.
module tb_pixel_write_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic [8:0]  x_in;
  logic [7:0]  y_in;
  logic [2:0]  color;
  logic        clear_ovf;
  logic        fb_ready;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        busy;
  logic        overflow;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  pixel_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .draw(draw), .x_in(x_in), .y_in(y_in),
    .color(color), .clear_ovf(clear_ovf), .fb_ready(fb_ready),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic d, input int x, input int y, input int c);
    draw  = d;
    x_in  = 9'(x);
    y_in  = 8'(y);
    color = 3'(c);
  endtask

  // Scoreboard for the random phase: expected {addr,data} in acceptance order.
  logic [19:0] sb_q[$];
  logic        mon_en = 1'b0;
  int          written = 0;

  always @(negedge clk) begin
    if (mon_en && fb_we && fb_ready) begin
      if (sb_q.size() == 0) begin
        chk("rand_unexpected_write", {12'd0, fb_addr, fb_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rand_write", {12'd0, fb_addr, fb_data}, {12'd0, sb_q.pop_front()});
        written++;
      end
    end
  end

  initial begin
    reset = 1'b1; clear_ovf = 1'b0; fb_ready = 1'b1;
    set_px(0, 0, 0, 0);
    #12;
    chk("reset_fb_we", fb_we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_addr", fb_addr, 0);
    reset = 1'b0;
    step();

    // 1: single pixel, one-cycle latency into the output register
    set_px(1, 5, 2, 5);
    step();
    set_px(0, 0, 0, 0);
    chk("t1_we_after_push", fb_we, 0);
    chk("t1_count_after_push", count, 1);
    step();
    chk("t1_we", fb_we, 1);
    chk("t1_addr", fb_addr, 645);
    chk("t1_data", fb_data, 5);
    step();
    chk("t1_we_done", fb_we, 0);
    chk("t1_busy_done", busy, 0);

    // 2: vertical line under stall, then drained at full rate
    fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_px(1, 100, 50 + i, 3);
      step();
    end
    set_px(0, 0, 0, 0);
    chk("t2_count_loaded", count, 9);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        chk("t2_stall_we", fb_we, 1);
        chk("t2_stall_addr", fb_addr, 16100);
      end
      step();
    end
    fb_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_we", fb_we, 1);
      chk("t2_addr", fb_addr, 32'((50 + i) * 320 + 100));
      step();
    end
    chk("t2_we_end", fb_we, 0);
    chk("t2_busy_end", busy, 0);

    // 3: 20 draws into DEPTH=16 while stalled -> 17 kept, 3 dropped
    fb_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_px(1, i, 0, i % 8);
      step();
      if (i == 16) begin
        chk("t3_count_full", count, 16);
        chk("t3_ovf_not_yet", overflow, 0);
      end
    end
    set_px(0, 0, 0, 0);
    chk("t3_count", count, 16);
    chk("t3_overflow", overflow, 1);
    fb_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk("t3_drain_we", fb_we, 1);
      chk("t3_drain_addr", fb_addr, 32'(i));
      chk("t3_drain_data", fb_data, 32'(i % 8));
      step();
    end
    chk("t3_drain_end_we", fb_we, 0);
    chk("t3_ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);

    // 4: clipping at the screen edges, and the largest legal address
    set_px(1, 320, 0, 1);
    step();
    set_px(1, 0, 240, 1);
    step();
    set_px(0, 0, 0, 0);
    chk("t4_clip_count", count, 0);
    step();
    chk("t4_clip_we", fb_we, 0);
    chk("t4_clip_ovf", overflow, 0);
    set_px(1, 319, 239, 6);
    step();
    set_px(0, 0, 0, 0);
    step();
    chk("t4_max_we", fb_we, 1);
    chk("t4_max_addr", fb_addr, 76799);
    chk("t4_max_data", fb_data, 6);
    step();

    // 5: asynchronous reset between edges during a burst that has overflowed
    fb_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      set_px(1, 10, i, 2);
      step();
    end
    set_px(0, 0, 0, 0);
    chk("t5_pre_ovf", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_we", fb_we, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_ovf", overflow, 0);
    #1;
    reset = 1'b0;
    step();
    fb_ready = 1'b1;
    set_px(1, 7, 1, 4);
    step();
    set_px(0, 0, 0, 0);
    step();
    chk("t5_post_we", fb_we, 1);
    chk("t5_post_addr", fb_addr, 327);
    chk("t5_post_data", fb_data, 4);
    step();
    chk("t5_post_busy", busy, 0);

    // 6: random pixels, fb_ready toggling every cycle, scoreboarded
    mon_en = 1'b1;
    begin
      int sent = 0;
      int budget = 0;
      while (sent < 200 && budget < 5000) begin
        fb_ready = ~fb_ready;
        if (sb_q.size() < DEPTH && $urandom_range(1, 0) == 1) begin
          int x = $urandom_range(319, 0);
          int y = $urandom_range(239, 0);
          int c = $urandom_range(7, 0);
          set_px(1, x, y, c);
          sb_q.push_back({17'(y * 320 + x), 3'(c)});
          sent++;
        end else begin
          set_px(0, 0, 0, 0);
        end
        step();
        budget++;
      end
      set_px(0, 0, 0, 0);
      budget = 0;
      while (busy && budget < 200) begin
        fb_ready = ~fb_ready;
        step();
        budget++;
      end
      fb_ready = 1'b1;
      step();
      chk("t6_sent", sent, 200);
      chk("t6_written", written, 200);
      chk("t6_queue_empty", sb_q.size(), 0);
      chk("t6_busy_end", busy, 0);
      chk("t6_no_overflow", overflow, 0);
    end
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
